pc_interrupt_sequencer: RTL

//   Parametrised program-counter generator with a multi-cycle interrupt/RTI sequencer for the pipelined core.

---
 rtl/pc_interrupt_sequencer_if.sv | 21 ++
 rtl/pc_interrupt_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_interrupt_sequencer_if.sv
// Shared data-memory port between the PC/interrupt sequencer and memory.
// Read data is valid the cycle after mem_rd.
interface pc_interrupt_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/pc_interrupt_sequencer.sv
// PC generator with reset-vector load and multi-cycle interrupt
// push / RTI pop sequencing over the shared data-memory port.
module pc_interrupt_sequencer #(
  parameter int          DATA_W   = 16,
  parameter int          PC_W     = 32,
  parameter int          NUM_IRQ  = 2,
  parameter int unsigned VEC_BASE = 0,
  parameter int unsigned SP_RESET = (1 << DATA_W) - 1,
  parameter int unsigned PC_INC   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               rti,
  input  logic [3:0]         ccr_in,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_en,
  output logic               flush,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic [3:0]         ccr_out,
  output logic               ccr_load,
  output logic               busy,
  pc_interrupt_sequencer_if.master mem
);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [3:0] {
    RST_HI, RST_LO, VEC_CAP, RUN,
    PUSH_F, PUSH_H, PUSH_L, VEC_HI, VEC_LO,
    POP_LO, POP_HI, POP_F, POP_CAP
  } state_e;

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    ret_pc_q;
  logic [DATA_W-1:0]  sp_q;
  logic               in_isr_q;
  logic [IW-1:0]      irq_idx_q;
  logic [NUM_IRQ-1:0] int_ack_q;
  logic               flush_q;
  logic [3:0]         ccr_q;
  logic               ccr_load_q;

  logic [IW-1:0]      sel;
  logic [NUM_IRQ-1:0] sel_oh;
  logic [DATA_W-1:0]  vec_a;
  logic [PC_W-1:0]    pc_inc;

  // Scan downwards so the lowest set index wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) sel = IW'(i);
    end
    sel_oh = NUM_IRQ'(1) << sel;
  end

  assign vec_a = DATA_W'(VEC_BASE)
               + DATA_W'({irq_idx_q, 1'b0})
               + DATA_W'(2);
  assign pc_inc = pc_q + PC_W'(PC_INC);

  always_ff @(posedge clk) begin
    int_ack_q  <= '0;
    flush_q    <= 1'b0;
    ccr_load_q <= 1'b0;
    if (reset) begin
      state_q   <= RST_HI;
      pc_q      <= '0;
      ret_pc_q  <= '0;
      sp_q      <= DATA_W'(SP_RESET);
      in_isr_q  <= 1'b0;
      irq_idx_q <= '0;
      ccr_q     <= '0;
    end else begin
      unique case (state_q)
        RST_HI: state_q <= RST_LO;
        RST_LO: begin
          pc_q[PC_W-1:DATA_W] <= mem.mem_rdata;
          state_q <= VEC_CAP;
        end
        VEC_CAP: begin
          pc_q[DATA_W-1:0] <= mem.mem_rdata;
          state_q <= RUN;
        end
        RUN: begin
          if (rti) begin
            state_q <= POP_LO;
          end else if (stall) begin
            pc_q <= pc_q;
          end else if (|irq && !in_isr_q) begin
            int_ack_q <= sel_oh;
            flush_q   <= 1'b1;
            in_isr_q  <= 1'b1;
            irq_idx_q <= sel;
            ret_pc_q  <= branch_taken ? branch_target : pc_inc;
            state_q   <= PUSH_F;
          end else if (branch_taken) begin
            pc_q <= branch_target;
          end else begin
            pc_q <= pc_inc;
          end
        end
        PUSH_F: begin
          sp_q <= sp_q - 1'b1;
          state_q <= PUSH_H;
        end
        PUSH_H: begin
          sp_q <= sp_q - 1'b1;
          state_q <= PUSH_L;
        end
        PUSH_L: begin
          sp_q <= sp_q - 1'b1;
          state_q <= VEC_HI;
        end
        VEC_HI: state_q <= VEC_LO;
        VEC_LO: begin
          pc_q[PC_W-1:DATA_W] <= mem.mem_rdata;
          state_q <= VEC_CAP;
        end
        POP_LO: state_q <= POP_HI;
        POP_HI: begin
          pc_q[DATA_W-1:0] <= mem.mem_rdata;
          state_q <= POP_F;
        end
        POP_F: begin
          pc_q[PC_W-1:DATA_W] <= mem.mem_rdata;
          state_q <= POP_CAP;
        end
        POP_CAP: begin
          ccr_q      <= mem.mem_rdata[3:0];
          ccr_load_q <= 1'b1;
          flush_q    <= 1'b1;
          sp_q       <= sp_q + DATA_W'(3);
          in_isr_q   <= 1'b0;
          state_q    <= RUN;
        end
        default: state_q <= RST_HI;
      endcase
    end
  end

  always_comb begin
    mem.mem_rd    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    unique case (state_q)
      RST_HI: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = DATA_W'(VEC_BASE);
      end
      RST_LO: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = DATA_W'(VEC_BASE) + DATA_W'(1);
      end
      VEC_HI: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = vec_a;
      end
      VEC_LO: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = vec_a + DATA_W'(1);
      end
      PUSH_F: begin
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = sp_q;
        mem.mem_wdata = {{(DATA_W-4){1'b0}}, ccr_in};
      end
      PUSH_H: begin
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = sp_q;
        mem.mem_wdata = ret_pc_q[PC_W-1:DATA_W];
      end
      PUSH_L: begin
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = sp_q;
        mem.mem_wdata = ret_pc_q[DATA_W-1:0];
      end
      POP_LO: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = sp_q + DATA_W'(1);
      end
      POP_HI: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = sp_q + DATA_W'(2);
      end
      POP_F: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = sp_q + DATA_W'(3);
      end
      default: ;
    endcase
  end

  assign pc       = pc_q;
  assign fetch_en = (state_q == RUN) && !stall;
  assign flush    = flush_q;
  assign int_ack  = int_ack_q;
  assign ccr_out  = ccr_q;
  assign ccr_load = ccr_load_q;
  assign busy     = (state_q != RUN);
endmodule
